// File: rtl/tt_wb_pkg.sv
// Shared constants, bus FSM state type and byte-lane helpers for the tt_wb_ctrl Wishbone register block.
package tt_wb_pkg;

  localparam logic [31:0] ID_DEFAULT = 32'h5454_0001;

  // Word offsets, i.e. wbs_adr_i[7:2]; byte offsets are these values times four.
  localparam logic [5:0] OFF_ID        = 6'h00;
  localparam logic [5:0] OFF_STATUS    = 6'h01;
  localparam logic [5:0] OFF_IRQ_PEND  = 6'h02;
  localparam logic [5:0] OFF_IRQ_MASK  = 6'h03;
  localparam logic [5:0] OFF_CTRL_BASE = 6'h04;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } bus_state_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int unsigned b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

  function automatic logic [31:0] low_mask(input int unsigned n);
    logic [31:0] m;
    for (int unsigned i = 0; i < 32; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/tt_wb_irq_ctrl.sv
// Interrupt controller: rising-edge detect, W1C pending register, mask register and the three
// grouped user_irq lines.
module tt_wb_irq_ctrl
  import tt_wb_pkg::*;
#(
  parameter int unsigned N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             pend_wr,
  input  logic             mask_wr,
  input  logic [31:0]      wdata,
  input  logic [31:0]      wmask,
  output logic [31:0]      pend,
  output logic [31:0]      mask,
  output logic [2:0]       user_irq
);

  localparam logic [31:0] VALID = low_mask(N_IRQ);

  logic [31:0] src;
  logic [31:0] hist;
  logic [31:0] rise;
  logic [31:0] clr;
  logic [2:0]  group;

  always_comb begin
    src = '0;
    src[N_IRQ-1:0] = irq_src;
  end

  assign rise = src & ~hist;
  assign clr  = pend_wr ? (wdata & wmask) : '0;

  // Set is ORed in after the clear so a coincident edge keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      pend <= '0;
    end else begin
      hist <= src & VALID;
      pend <= ((pend & ~clr) | rise) & VALID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
    end else if (mask_wr) begin
      mask <= ((mask & ~wmask) | (wdata & wmask)) & VALID;
    end
  end

  always_comb begin
    group = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      group[i % 3] = group[i % 3] | (pend[i] & mask[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      user_irq <= '0;
    end else begin
      user_irq <= group;
    end
  end

endmodule

// File: rtl/tt_wb_ctrl.sv
// Wishbone classic register slave: ID, STATUS, IRQ_PEND/IRQ_MASK and N_CTRL control registers.
// Define TT_WB_LA_MIRROR_EN to mirror CTRL[0], IRQ_PEND and IRQ_MASK onto la_data_out.
module tt_wb_ctrl
  import tt_wb_pkg::*;
#(
  parameter int unsigned N_CTRL    = 4,
  parameter int unsigned N_IRQ     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE  = ID_DEFAULT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [32*N_CTRL-1:0] ctrl_o,
  input  logic [31:0]         stat_i,
  input  logic [N_IRQ-1:0]    irq_src_i,
  output logic [2:0]          user_irq,
  output logic [127:0]        la_data_out
);

  bus_state_t  state;
  logic        hit;
  logic        start;
  logic        wr;
  logic [5:0]  offset;
  logic [31:0] wmask;
  logic [31:0] rdata;
  logic [31:0] irq_pend;
  logic [31:0] irq_mask;
  logic [31:0] ctrl_reg [N_CTRL];
  logic        unused_adr;

  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign offset     = wbs_adr_i[7:2];
  assign start      = (state == ST_IDLE) & hit;
  assign wr         = start & wbs_we_i;
  assign wmask      = lane_mask(wbs_sel_i);
  assign unused_adr = ^wbs_adr_i[1:0];

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_ID:       rdata = ID_VALUE;
      OFF_STATUS:   rdata = stat_i;
      OFF_IRQ_PEND: rdata = irq_pend;
      OFF_IRQ_MASK: rdata = irq_mask;
      default: begin
        for (int unsigned k = 0; k < N_CTRL; k++) begin
          if (offset == OFF_CTRL_BASE + 6'(k)) rdata = ctrl_reg[k];
        end
      end
    endcase
  end

  // Side effects and the read sample both happen on the IDLE->ACK edge, so a reset
  // during ACK simply drops the pending ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state     <= ST_ACK;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wbs_we_i ? '0 : rdata;
          end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < int'(N_CTRL); k++) begin : g_ctrl
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        ctrl_reg[k] <= '0;
      end else if (wr && offset == OFF_CTRL_BASE + 6'(k)) begin
        ctrl_reg[k] <= (ctrl_reg[k] & ~wmask) | (wbs_dat_i & wmask);
      end
    end
    assign ctrl_o[32*k +: 32] = ctrl_reg[k];
  end

  tt_wb_irq_ctrl #(
    .N_IRQ (N_IRQ)
  ) u_irq (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .irq_src  (irq_src_i),
    .pend_wr  (wr && offset == OFF_IRQ_PEND),
    .mask_wr  (wr && offset == OFF_IRQ_MASK),
    .wdata    (wbs_dat_i),
    .wmask    (wmask),
    .pend     (irq_pend),
    .mask     (irq_mask),
    .user_irq (user_irq)
  );

`ifdef TT_WB_LA_MIRROR_EN
  assign la_data_out = {32'h0, irq_mask, irq_pend, ctrl_reg[0]};
`else
  assign la_data_out = '0;
`endif

endmodule

// File: tb/tb_tt_wb_ctrl.sv
// Self-checking bench for tt_wb_ctrl (default parameters); read expectations go through a scoreboard queue.
module tb_tt_wb_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, dat;
  logic         ack;
  logic [31:0]  dat_o;
  logic [127:0] ctrl_o;
  logic [31:0]  stat;
  logic [7:0]   irq_src;
  logic [2:0]   user_irq;
  logic [127:0] la;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  logic [31:0]  exp_q [$];
  logic [31:0]  rd_v;
  int           lat_v;
  logic         idle_ok;
  logic [31:0]  ctrl0_m;
  logic [31:0]  e;

  always #5 clk = ~clk;

  tt_wb_ctrl dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dat_o),
    .ctrl_o      (ctrl_o),
    .stat_i      (stat),
    .irq_src_i   (irq_src),
    .user_irq    (user_irq),
    .la_data_out (la)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One transfer, bounded to 4 cycles; reports ack latency, read data and whether the bus idled after.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    lat_v = 0; rd_v = '0;
    for (int c = 1; c <= 4 && lat_v == 0; c++) begin
      @(posedge clk);
      #1;
      if (ack === 1'b1) begin
        lat_v = c;
        rd_v  = dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step(1);
    idle_ok = (ack === 1'b0) && (dat_o === 32'h0);
  endtask

  task automatic read_sb(input logic [31:0] a, input logic [31:0] expv);
    exp_q.push_back(expv);
    bus(1'b0, a, 32'h0, 4'hf);
  endtask

  function automatic logic [127:0] la_exp(input logic [31:0] c0, input logic [31:0] p, input logic [31:0] m);
`ifdef TT_WB_LA_MIRROR_EN
    return {32'h0, m, p, c0};
`else
    return 128'h0;
`endif
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    step(3);
    vectors++;
    if ({ack, dat_o, ctrl_o, user_irq, la} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ack=%b dat=%h ctrl=%h irq=%b la=%h, want all zero", ack, dat_o, ctrl_o, user_irq, la);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_map;
    read_sb(32'h3000_0000, 32'h5454_0001);
    e = exp_q.pop_front();
    vectors++;
    if (lat_v != 1 || rd_v !== e || !idle_ok) begin
      miscompares++;
      $display("FAIL id_read: dat=%h lat=%0d idle=%b, want %h lat=1 idle=1", rd_v, lat_v, idle_ok, e);
    end
    read_sb(32'h3000_00FC, 32'h0);
    e = exp_q.pop_front();
    vectors++;
    if (lat_v != 1 || rd_v !== e) begin
      miscompares++;
      $display("FAIL unmapped_read: dat=%h lat=%0d, want %h lat=1", rd_v, lat_v, e);
    end
    read_sb(32'h3000_0004, stat);
    e = exp_q.pop_front();
    vectors++;
    if (lat_v != 1 || rd_v !== e) begin
      miscompares++;
      $display("FAIL status_read: dat=%h lat=%0d, want %h", rd_v, lat_v, e);
    end
    bus(1'b1, 32'h3000_0020, 32'hFFFF_FFFF, 4'hf);
    vectors++;
    if (lat_v != 1 || ctrl_o !== '0) begin
      miscompares++;
      $display("FAIL unmapped_write: lat=%0d ctrl=%h, want lat=1 ctrl=0", lat_v, ctrl_o);
    end
    // Non-hit cycles: wrong base, then cyc low with a matching address.
    cyc = 1'b1; stb = 1'b1; adr = 32'h3100_0000; we = 1'b0;
    lat_v = 0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (ack !== 1'b0) lat_v++;
    end
    cyc = 1'b0; adr = 32'h3000_0000;
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (ack !== 1'b0) lat_v++;
    end
    stb = 1'b0;
    vectors++;
    if (lat_v != 0) begin
      miscompares++;
      $display("FAIL no_hit_ack: acks=%0d, want 0", lat_v);
    end
  endtask

  task automatic test_ctrl_write;
    bus(1'b1, 32'h3000_0014, 32'hA5A5_A5A5, 4'b0101);
    vectors++;
    if (lat_v != 1 || ctrl_o[63:32] !== 32'h00A5_00A5) begin
      miscompares++;
      $display("FAIL ctrl1_lanes: ctrl1=%h lat=%0d, want 00a500a5 lat=1", ctrl_o[63:32], lat_v);
    end
    read_sb(32'h3000_0014, 32'h00A5_00A5);
    e = exp_q.pop_front();
    vectors++;
    if (rd_v !== e) begin
      miscompares++;
      $display("FAIL ctrl1_read: dat=%h, want %h", rd_v, e);
    end
    ctrl0_m = 32'hDEAD_BEEF;
    bus(1'b1, 32'h3000_0010, ctrl0_m, 4'hf);
    bus(1'b1, 32'h3000_0010, 32'h0000_1100, 4'b0010);
    ctrl0_m = 32'hDEAD_11EF;
    read_sb(32'h3000_0010, ctrl0_m);
    e = exp_q.pop_front();
    vectors++;
    if (rd_v !== e || ctrl_o[31:0] !== e || ctrl_o[127:64] !== '0) begin
      miscompares++;
      $display("FAIL ctrl0_rmw: dat=%h ctrl=%h, want %h", rd_v, ctrl_o, e);
    end
    vectors++;
    if (la !== la_exp(ctrl0_m, 32'h0, 32'h0)) begin
      miscompares++;
      $display("FAIL la_ctrl: la=%h, want %h", la, la_exp(ctrl0_m, 32'h0, 32'h0));
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] pattern;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0000; sel = 4'hf;
    pattern = '0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        cyc = 1'b0; stb = 1'b0;
      end
      step(1);
      pattern[c] = ack;
    end
    vectors++;
    if (pattern !== 4'b0101) begin
      miscompares++;
      $display("FAIL back_to_back: ack pattern=%b, want 0101", pattern);
    end
  endtask

  task automatic test_irq;
    bus(1'b1, 32'h3000_000C, 32'hFFFF_FFFF, 4'hf);
    read_sb(32'h3000_000C, 32'h0000_00FF);
    e = exp_q.pop_front();
    vectors++;
    if (rd_v !== e) begin
      miscompares++;
      $display("FAIL mask_width: dat=%h, want %h", rd_v, e);
    end
    bus(1'b1, 32'h3000_000C, 32'h0000_0010, 4'hf);
    irq_src = 8'h10;
    step(1);
    irq_src = 8'h00;
    step(2);
    vectors++;
    if (user_irq !== 3'b010 || la !== la_exp(ctrl0_m, 32'h10, 32'h10)) begin
      miscompares++;
      $display("FAIL irq4_line: user_irq=%b la=%h, want 010", user_irq, la);
    end
    read_sb(32'h3000_0008, 32'h0000_0010);
    e = exp_q.pop_front();
    vectors++;
    if (rd_v !== e) begin
      miscompares++;
      $display("FAIL irq4_pend: dat=%h, want %h", rd_v, e);
    end
    irq_src = 8'h01;
    step(1);
    irq_src = 8'h00;
    step(2);
    read_sb(32'h3000_0008, 32'h0000_0011);
    e = exp_q.pop_front();
    vectors++;
    if (rd_v !== e || user_irq !== 3'b010) begin
      miscompares++;
      $display("FAIL irq0_masked: dat=%h user_irq=%b, want %h 010", rd_v, user_irq, e);
    end
    bus(1'b1, 32'h3000_0008, 32'h0000_0010, 4'hf);
    step(1);
    vectors++;
    if (user_irq !== 3'b000) begin
      miscompares++;
      $display("FAIL irq4_clear: user_irq=%b, want 000", user_irq);
    end
    bus(1'b1, 32'h3000_0008, 32'h0000_0001, 4'hf);
    read_sb(32'h3000_0008, 32'h0);
    e = exp_q.pop_front();
    vectors++;
    if (rd_v !== e) begin
      miscompares++;
      $display("FAIL pend_cleared: dat=%h, want %h", rd_v, e);
    end
  endtask

  task automatic test_w1c_race;
    irq_src = 8'h10;
    step(1);
    irq_src = 8'h00;
    step(1);
    // Clear and a fresh rising edge land on the same clock edge.
    irq_src = 8'h10;
    bus(1'b1, 32'h3000_0008, 32'h0000_0010, 4'hf);
    read_sb(32'h3000_0008, 32'h0000_0010);
    e = exp_q.pop_front();
    vectors++;
    if (rd_v !== e) begin
      miscompares++;
      $display("FAIL w1c_race: pend=%h, want %h", rd_v, e);
    end
    bus(1'b1, 32'h3000_0008, 32'h0000_0010, 4'hf);
    irq_src = 8'h00;
    read_sb(32'h3000_0008, 32'h0);
    e = exp_q.pop_front();
    vectors++;
    if (rd_v !== e) begin
      miscompares++;
      $display("FAIL w1c_after: pend=%h, want %h", rd_v, e);
    end
  endtask

  task automatic test_reset_during_ack;
    int acks;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0010; dat = 32'h1234_5678; sel = 4'hf;
    step(1);
    vectors++;
    if (ack !== 1'b1 || la !== la_exp(32'h1234_5678, 32'h0, 32'h10)) begin
      miscompares++;
      $display("FAIL ack_before_reset: ack=%b la=%h", ack, la);
    end
    rst = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    irq_src = 8'h04;
    step(1);
    acks = (ack !== 1'b0) ? 1 : 0;
    step(2);
    vectors++;
    if (ctrl_o !== '0 || la !== '0 || user_irq !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_abort: ctrl=%h la=%h irq=%b, want 0", ctrl_o, la, user_irq);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (ack !== 1'b0) acks++;
    end
    vectors++;
    if (acks != 0) begin
      miscompares++;
      $display("FAIL reset_no_ack: acks=%0d, want 0", acks);
    end
    read_sb(32'h3000_0008, 32'h0000_0004);
    e = exp_q.pop_front();
    vectors++;
    if (rd_v !== e) begin
      miscompares++;
      $display("FAIL held_src_after_reset: pend=%h, want %h", rd_v, e);
    end
    irq_src = 8'h00;
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; dat = '0; stat = 32'h1234_5678; irq_src = '0;
    ctrl0_m = '0;
    step(1);
    test_reset;
    test_map;
    test_ctrl_write;
    test_back_to_back;
    test_irq;
    test_w1c_race;
    test_reset_during_ack;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tt_wb_ctrl.md
TT_WB_CTRL -- requirements
Module: tt_wb_ctrl

Interface
REQ-001 Parameter N_CTRL, default 4, number of 32-bit RW control registers (legal 1..8).
REQ-002 Parameter N_IRQ, default 8, number of interrupt sources (legal 1..32).
REQ-003 Parameter BASE_ADDR, default 32'h3000_0000, decode base; bits [7:0] ignored.
REQ-004 Parameter ID_VALUE, default 32'h5454_0001, read-only identification word.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: wb_clk_i and wb_rst_i.
REQ-006 wb_clk_i  in  1  sole clock, rising edge.
REQ-007 wb_rst_i  in  1  synchronous active-high reset.
REQ-008 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
REQ-009 wbs_sel_i  in  4  byte enables; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-010 wbs_ack_o  out  1  transfer acknowledge; wbs_dat_o  out  32  read data.
REQ-011 ctrl_o  out  32*N_CTRL  control registers, CTRL[k] at bits [32k+31:32k].
REQ-012 stat_i  in  32  status word from the user area, sampled on read.
REQ-013 irq_src_i  in  N_IRQ  interrupt sources, synchronous to wb_clk_i.
REQ-014 user_irq  out  3  interrupt lines to the management core.
REQ-015 la_data_out  out  128  logic-analyzer return data.

Function
REQ-016 Hit SHALL be wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]); offset = wbs_adr_i[7:2].
REQ-017 Map SHALL be: 0x00 ID (RO), 0x04 STATUS (RO, stat_i), 0x08 IRQ_PEND (W1C), 0x0C IRQ_MASK (RW), 0x10+4k CTRL[k] (RW), k < N_CTRL.
REQ-018 Bus FSM SHALL have states IDLE and ACK: IDLE->ACK on hit; ACK->IDLE unconditionally.
REQ-019 wbs_ack_o SHALL be high only in ACK, exactly one cycle, one cycle after the hit is first seen.
REQ-020 A hit present in the ACK cycle SHALL NOT start a new transfer; the next transfer starts from IDLE.
REQ-021 Write side effects SHALL occur on the IDLE->ACK edge; only byte lanes with wbs_sel_i set are updated.
REQ-022 wbs_dat_o SHALL be registered, valid while wbs_ack_o is high, and zero at all other times.
REQ-023 Unmapped offsets SHALL be acknowledged normally, read as zero, and ignore writes; non-hit cycles are never acknowledged.
REQ-024 IRQ_PEND[i] SHALL set on the cycle after a 0->1 transition of irq_src_i[i]; bits >= N_IRQ read zero.
REQ-025 When a set and a W1C clear of the same bit coincide, set SHALL win.
REQ-026 IRQ_MASK bits >= N_IRQ SHALL read zero and ignore writes.
REQ-027 user_irq[j] SHALL be the registered OR of (IRQ_PEND[i] & IRQ_MASK[i]) over all i with i mod 3 == j.

Reset
REQ-028 While wb_rst_i is high: FSM=IDLE, wbs_ack_o=0, wbs_dat_o=0, ctrl_o=0, IRQ_PEND=0, IRQ_MASK=0, user_irq=0, la_data_out=0.
REQ-029 The edge-detect history SHALL reset to 0, so a source held high through reset release sets its pending bit one cycle after release.
REQ-030 Reset asserted during ACK SHALL abort the transfer with no ack and no register update.

Configuration
REQ-031 With TT_WB_LA_MIRROR_EN defined, la_data_out[31:0] SHALL equal CTRL[0], [63:32] IRQ_PEND, [95:64] IRQ_MASK, and [127:96] zero.
REQ-032 Without TT_WB_LA_MIRROR_EN, la_data_out SHALL be constant zero and no mirror logic SHALL be present.

Structure
REQ-033 Package tt_wb_pkg SHALL hold the register offset constants, the ID default, and the bus-FSM state enum.
REQ-034 Sub-module tt_wb_irq_ctrl SHALL contain edge detect, IRQ_PEND, IRQ_MASK and user_irq generation; the top level contains decode, FSM and CTRL registers.

Verification
REQ-035 Read 0x3000_0000 -> ack exactly 1 cycle after stb, dat=0x5454_0001; read 0x3000_00FC -> ack, dat=0.
REQ-036 Write 0x3000_0014 data 0xA5A5_A5A5 with sel=4'b0101 after reset -> CTRL[1]=0x00A5_00A5.
REQ-037 Hold cyc/stb for 4 cycles -> acks on cycles 2 and 4 only.
REQ-038 Set IRQ_MASK=0x10 and pulse irq_src_i[4] -> IRQ_PEND=0x10 and user_irq=3'b010; write 0x10 to IRQ_PEND -> user_irq=0.
REQ-039 Issue a W1C clear of bit 4 in the same cycle as a rising edge on irq_src_i[4] -> IRQ_PEND[4] stays 1.
REQ-040 Assert reset during ACK of a write to CTRL[0] -> CTRL[0]=0 and no further ack; with TT_WB_LA_MIRROR_EN, la_data_out[31:0] tracks CTRL[0] writes.
